noc_link_rx_deser: RTL and testbench

NOC_LINK_RX_DESER -- requirements
Module: noc_link_rx_deser

---
 rtl/noc_link_rx_deser.sv | 160 ++++++++++++++++
 tb/tb_noc_link_rx_deser.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_link_rx_deser.sv
// Receive side of a credit-based NoC link: buffers incoming flits, returns one credit
// per pop, and packs SERIALIZATION_FACTOR flits into one AXI-Stream beat.
module noc_link_rx_deser #(
  parameter int TDATA_WIDTH          = 128,
  parameter int TDEST_WIDTH          = 4,
  parameter int TID_WIDTH            = 2,
  parameter int SERIALIZATION_FACTOR = 1,
  parameter int BUFFER_DEPTH         = 2,
  localparam int FLIT_WIDTH          = TDATA_WIDTH / SERIALIZATION_FACTOR,
  localparam int DEST_WIDTH          = TDEST_WIDTH + TID_WIDTH,
  localparam int LEVEL_W             = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                   clk_noc,
  input  logic                   rst_noc_sync,
  input  logic [FLIT_WIDTH-1:0]  data_in,
  input  logic [DEST_WIDTH-1:0]  dest_in,
  input  logic                   is_tail_in,
  input  logic                   send_in,
  output logic                   credit_out,
  output logic                   axis_out_tvalid,
  input  logic                   axis_out_tready,
  output logic [TDATA_WIDTH-1:0] axis_out_tdata,
  output logic                   axis_out_tlast,
  output logic [TID_WIDTH-1:0]   axis_out_tid,
  output logic [TDEST_WIDTH-1:0] axis_out_tdest,
  output logic [LEVEL_W-1:0]     fifo_level,
  output logic                   overflow_err,
  output logic                   tail_align_err
);

  localparam int SF      = SERIALIZATION_FACTOR;
  localparam int PTR_W   = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CNT_W   = (SF > 1) ? $clog2(SF) : 1;
  localparam int ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;

  if ((TDATA_WIDTH % SERIALIZATION_FACTOR) != 0 || BUFFER_DEPTH < 1) begin : g_bad_params
    $error("noc_link_rx_deser: TDATA_WIDTH must be a multiple of SERIALIZATION_FACTOR and BUFFER_DEPTH >= 1");
  end

  logic [ENTRY_W-1:0]     mem_q [BUFFER_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0]     level_q, level_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TDATA_WIDTH-1:0] partial_q, partial_d;
  logic [DEST_WIDTH-1:0]  dest0_q, dest0_d;
  logic                   valid_q, valid_d;
  logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                   tlast_q, tlast_d;
  logic [TID_WIDTH-1:0]   tid_q, tid_d;
  logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
  logic                   credit_q;
  logic                   ovf_q, ovf_d;
  logic                   terr_q, terr_d;

  logic                   empty, full, last_flit, pop, push;
  logic [FLIT_WIDTH-1:0]  head_data;
  logic [DEST_WIDTH-1:0]  head_dest;
  logic                   head_tail;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty     = (level_q == '0);
  assign full      = (level_q == LEVEL_W'(BUFFER_DEPTH));
  assign last_flit = (cnt_q == CNT_W'(SF - 1));
  assign {head_data, head_dest, head_tail} = mem_q[rd_ptr_q];

  // Output register: tvalid/payload hold until tvalid & tready; a new beat may load in
  // the same cycle the current one is accepted.
  assign pop  = !empty && (!last_flit || !valid_q || axis_out_tready);
  // A full FIFO still accepts a flit when the head leaves in the same cycle.
  assign push = send_in && (!full || pop);

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + LEVEL_W'(1);
    else if (pop && !push) level_d = level_q - LEVEL_W'(1);
    ovf_d = ovf_q | (send_in && full && !pop);
  end

  always_comb begin
    cnt_d     = cnt_q;
    partial_d = partial_q;
    dest0_d   = dest0_q;
    valid_d   = valid_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    tid_d     = tid_q;
    tdest_d   = tdest_q;
    terr_d    = terr_q;
    if (valid_q && axis_out_tready) valid_d = 1'b0;
    if (pop) begin
      if (head_tail && !last_flit) terr_d = 1'b1;
      if (last_flit) begin
        valid_d = 1'b1;
        tdata_d = partial_q;
        tdata_d[(SF-1)*FLIT_WIDTH +: FLIT_WIDTH] = head_data;
        {tid_d, tdest_d} = (cnt_q == '0) ? head_dest : dest0_q;
        tlast_d = head_tail;
        cnt_d   = '0;
      end else begin
        partial_d[cnt_q*FLIT_WIDTH +: FLIT_WIDTH] = head_data;
        if (cnt_q == '0) dest0_d = head_dest;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_noc) begin
    if (push && !rst_noc_sync) mem_q[wr_ptr_q] <= {data_in, dest_in, is_tail_in};
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      cnt_q     <= '0;
      partial_q <= '0;
      dest0_q   <= '0;
      valid_q   <= 1'b0;
      tdata_q   <= '0;
      tlast_q   <= 1'b0;
      tid_q     <= '0;
      tdest_q   <= '0;
      credit_q  <= 1'b0;
      ovf_q     <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      partial_q <= partial_d;
      dest0_q   <= dest0_d;
      valid_q   <= valid_d;
      tdata_q   <= tdata_d;
      tlast_q   <= tlast_d;
      tid_q     <= tid_d;
      tdest_q   <= tdest_d;
      credit_q  <= pop;
      ovf_q     <= ovf_d;
      terr_q    <= terr_d;
    end
  end

  assign credit_out      = credit_q;
  assign axis_out_tvalid = valid_q;
  assign axis_out_tdata  = tdata_q;
  assign axis_out_tlast  = tlast_q;
  assign axis_out_tid    = tid_q;
  assign axis_out_tdest  = tdest_q;
  assign fifo_level      = level_q;
  assign overflow_err    = ovf_q;
  assign tail_align_err  = terr_q;

endmodule

// File: tb/tb_noc_link_rx_deser.sv
// Bench for noc_link_rx_deser: instance A (SF=1, depth 2, 8-bit beats) and
// instance B (SF=4, depth 3, 128-bit beats).
module tb_noc_link_rx_deser;

  localparam int BEAT_W = 1 + 2 + 4 + 128;
  localparam int B_DEPTH = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic       rst_a, a_tail, a_send, a_credit, a_tvalid, a_tready, a_tlast, a_ovf, a_terr;
  logic [7:0] a_data, a_tdata;
  logic [5:0] a_dest;
  logic [1:0] a_tid, a_level;
  logic [3:0] a_tdest;

  // Instance B signals
  logic         rst_b, b_tail, b_send, b_credit, b_tvalid, b_tready, b_tlast, b_ovf, b_terr;
  logic [31:0]  b_data;
  logic [127:0] b_tdata;
  logic [5:0]   b_dest;
  logic [1:0]   b_tid, b_level;
  logic [3:0]   b_tdest;

  noc_link_rx_deser #(
    .TDATA_WIDTH(8), .TDEST_WIDTH(4), .TID_WIDTH(2),
    .SERIALIZATION_FACTOR(1), .BUFFER_DEPTH(2)
  ) u_dut_a (
    .clk_noc(clk), .rst_noc_sync(rst_a),
    .data_in(a_data), .dest_in(a_dest), .is_tail_in(a_tail), .send_in(a_send),
    .credit_out(a_credit),
    .axis_out_tvalid(a_tvalid), .axis_out_tready(a_tready), .axis_out_tdata(a_tdata),
    .axis_out_tlast(a_tlast), .axis_out_tid(a_tid), .axis_out_tdest(a_tdest),
    .fifo_level(a_level), .overflow_err(a_ovf), .tail_align_err(a_terr)
  );

  noc_link_rx_deser #(
    .TDATA_WIDTH(128), .TDEST_WIDTH(4), .TID_WIDTH(2),
    .SERIALIZATION_FACTOR(4), .BUFFER_DEPTH(B_DEPTH)
  ) u_dut_b (
    .clk_noc(clk), .rst_noc_sync(rst_b),
    .data_in(b_data), .dest_in(b_dest), .is_tail_in(b_tail), .send_in(b_send),
    .credit_out(b_credit),
    .axis_out_tvalid(b_tvalid), .axis_out_tready(b_tready), .axis_out_tdata(b_tdata),
    .axis_out_tlast(b_tlast), .axis_out_tid(b_tid), .axis_out_tdest(b_tdest),
    .fifo_level(b_level), .overflow_err(b_ovf), .tail_align_err(b_terr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [BEAT_W-1:0] act,
                       input logic [BEAT_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Credit pulse counter for B, sampled mid-cycle
  int b_cred_cnt = 0;
  always @(negedge clk) if (b_credit === 1'b1) b_cred_cnt++;

  // Scoreboard for the random phase on B
  logic [BEAT_W-1:0] exp_q[$];
  logic              sb_en = 1'b0;
  logic              prev_v = 1'b0, prev_r = 1'b0;
  logic [BEAT_W-1:0] prev_beat = '0;

  always @(negedge clk) begin
    if (sb_en) begin
      if (prev_v && !prev_r)
        check("rand_hold", {1'b0, b_tvalid, b_tlast, b_tid, b_tdest, b_tdata[127:1]},
              {1'b0, 1'b1, prev_beat[BEAT_W-1:1]});
      if (b_tvalid && b_tready) begin
        if (exp_q.size() == 0) check("rand_unexpected_beat", 1, 0);
        else check("rand_beat", {b_tlast, b_tid, b_tdest, b_tdata}, exp_q.pop_front());
      end
      prev_v    = b_tvalid;
      prev_r    = b_tready;
      prev_beat = {b_tlast, b_tid, b_tdest, b_tdata};
    end
  end

  // Table for instance A
  typedef struct {
    logic       send;
    logic [7:0] data;
    logic [5:0] dest;
    logic       tail;
    logic       tready;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_last;
    logic [1:0] exp_tid;
    logic [3:0] exp_tdest;
    logic [1:0] exp_level;
    logic       exp_credit;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic b_flit(input logic [31:0] d, input logic [5:0] dest, input logic tail);
    b_send = 1'b1; b_data = d; b_dest = dest; b_tail = tail;
    @(posedge clk); #1;
    b_send = 1'b0;
  endtask

  task automatic b_idle(input int n);
    b_send = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_b_valid(input string name);
    int i;
    i = 0;
    while (b_tvalid !== 1'b1 && i < 20) begin @(posedge clk); #1; i++; end
    check(name, b_tvalid, 1);
  endtask

  initial begin
    int credits, sent, cyc, c0;
    logic [127:0] m_data;
    logic [5:0]   m_dest0;
    logic [31:0]  d;
    logic [5:0]   dst;
    logic         tl;

    vecs[0]  = '{1'b1, 8'hA5, 6'b10_0011, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'd0, 2'd1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 6'b00_0000, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 2'd2, 4'd3, 2'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 6'b00_0000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h11, 6'b01_0101, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 4'd0, 2'd1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h22, 6'b11_1010, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 2'd1, 4'd5, 2'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 8'h33, 6'b00_0001, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 2'd1, 4'd5, 2'd2, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h44, 6'b00_0000, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 2'd1, 4'd5, 2'd2, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 6'b00_0000, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 2'd3, 4'hA, 2'd1, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 6'b00_0000, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 2'd0, 4'd1, 2'd0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 6'b00_0000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 6'b00_0000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b1};

    rst_a = 1'b1; a_send = 1'b1; a_data = 8'hFF; a_dest = '1; a_tail = 1'b1; a_tready = 1'b0;
    rst_b = 1'b1; b_send = 1'b1; b_data = '1;    b_dest = '1; b_tail = 1'b1; b_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_tvalid", a_tvalid, 0);
    check("rst_a_level",  a_level,  0);
    check("rst_a_credit", a_credit, 0);
    check("rst_a_flags",  {a_ovf, a_terr}, 0);
    check("rst_a_payload", {a_tdata, a_tlast, a_tid, a_tdest}, 0);
    check("rst_b_state", {b_tvalid, b_level, b_credit, b_ovf, b_terr}, 0);
    check("rst_b_payload", {b_tdata, b_tlast, b_tid, b_tdest}, 0);
    rst_a = 1'b0; rst_b = 1'b0; a_send = 1'b0; b_send = 1'b0;
    @(posedge clk); #1;

    // Instance A: single flit latency, then back-pressure and overflow
    for (int i = 0; i < 11; i++) begin
      a_send = vecs[i].send; a_data = vecs[i].data; a_dest = vecs[i].dest;
      a_tail = vecs[i].tail; a_tready = vecs[i].tready;
      @(posedge clk); #1;
      check($sformatf("a_row%0d_tvalid", i), a_tvalid, vecs[i].exp_valid);
      check($sformatf("a_row%0d_level", i),  a_level,  vecs[i].exp_level);
      check($sformatf("a_row%0d_credit", i), a_credit, vecs[i].exp_credit);
      check($sformatf("a_row%0d_ovf", i),    a_ovf,    vecs[i].exp_ovf);
      check($sformatf("a_row%0d_terr", i),   a_terr,   0);
      if (vecs[i].exp_valid)
        check($sformatf("a_row%0d_payload", i), {a_tdata, a_tlast, a_tid, a_tdest},
              {vecs[i].exp_data, vecs[i].exp_last, vecs[i].exp_tid, vecs[i].exp_tdest});
    end
    a_send = 1'b0;

    // Instance B: four flits, one beat, flit 0 in the low word
    b_tready = 1'b1;
    c0 = b_cred_cnt;
    b_flit(32'h1, 6'b01_1001, 1'b0);
    b_flit(32'h2, 6'b00_0000, 1'b0);
    b_flit(32'h3, 6'b00_0000, 1'b0);
    b_flit(32'h4, 6'b11_1111, 1'b1);
    wait_b_valid("sf4_beat_valid");
    check("sf4_beat", {b_tlast, b_tid, b_tdest, b_tdata},
          {1'b1, 2'd1, 4'd9, 128'h00000004_00000003_00000002_00000001});
    b_idle(4);
    check("sf4_credits", b_cred_cnt - c0, 4);
    check("sf4_no_err", {b_ovf, b_terr, b_tvalid}, 0);

    // Tail on flit 0: error flag, beat still assembled
    b_flit(32'h5, 6'b10_0010, 1'b1);
    b_flit(32'h6, 6'b00_0000, 1'b0);
    b_flit(32'h7, 6'b00_0000, 1'b0);
    b_flit(32'h8, 6'b00_0000, 1'b0);
    wait_b_valid("talign_valid");
    check("talign_beat", {b_tlast, b_tid, b_tdest, b_tdata},
          {1'b0, 2'd2, 4'd2, 128'h00000008_00000007_00000006_00000005});
    check("talign_err", b_terr, 1);
    b_idle(3);

    // Reset with a full output, a partial beat and one buffered flit
    b_tready = 1'b0;
    for (int i = 0; i < 8; i++) b_flit(32'hA0 + 32'(i), 6'b01_0001, (i % 4) == 3);
    b_idle(6);
    check("prerst_level", b_level, 1);
    check("prerst_tvalid", b_tvalid, 1);
    c0 = b_cred_cnt;
    rst_b = 1'b1; b_send = 1'b1; b_data = 32'hDEAD;
    @(posedge clk); #1;
    rst_b = 1'b0; b_send = 1'b0;
    check("rst_mid_state", {b_tvalid, b_level, b_credit, b_ovf, b_terr}, 0);
    b_idle(5);
    check("rst_mid_no_credit", b_cred_cnt - c0, 0);
    check("rst_mid_level", b_level, 0);
    b_tready = 1'b1;
    b_flit(32'hC0, 6'b11_0110, 1'b0);
    b_flit(32'hC1, 6'b00_0000, 1'b0);
    b_flit(32'hC2, 6'b00_0000, 1'b0);
    b_flit(32'hC3, 6'b00_0000, 1'b1);
    wait_b_valid("postrst_valid");
    check("postrst_beat", {b_tlast, b_tid, b_tdest, b_tdata},
          {1'b1, 2'd3, 4'd6, 128'h000000C3_000000C2_000000C1_000000C0});
    b_idle(5);

    // Random traffic on B obeying credits, checked against the flit-queue model
    sb_en = 1'b1;
    credits = B_DEPTH; sent = 0; cyc = 0;
    m_data = '0; m_dest0 = '0;
    while ((sent < 1000 || exp_q.size() > 0) && cyc < 30000) begin
      if (b_credit) credits++;
      if (sent < 1000 && credits > 0 && $urandom_range(0, 3) != 0) begin
        d   = $urandom;
        dst = 6'($urandom_range(0, 63));
        tl  = ((sent % 4) == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
        b_send = 1'b1; b_data = d; b_dest = dst; b_tail = tl;
        credits--;
        if ((sent % 4) == 0) m_dest0 = dst;
        m_data[(sent % 4) * 32 +: 32] = d;
        if ((sent % 4) == 3) exp_q.push_back({tl, m_dest0, m_data});
        sent++;
      end else begin
        b_send = 1'b0;
      end
      b_tready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    b_send = 1'b0;
    b_tready = 1'b1;
    check("rand_drained", exp_q.size(), 0);
    repeat (6) begin
      if (b_credit) credits++;
      @(posedge clk); #1;
    end
    sb_en = 1'b0;
    check("rand_credits_returned", credits, B_DEPTH);
    check("rand_no_err", {b_ovf, b_terr}, 0);
    check("rand_level_empty", b_level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
